// File: rtl/i2c_slave_ctrl.sv
// Purpose: I2C target controller; answers SLAVE_ADDR with ACK and runs a word-address write path and a read path on a register port.
// Latency: bus pins reach internal edges after a 2-flop sync plus FILTER_LEN clks; reg_wen/reg_ren pulse 1 clk after the qualifying scl rise.
// Backpressure: none; reg_rdata must be valid exactly 1 clk after reg_ren and scl is never stretched.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_scl/i_sda_i sampled bus lines;
//        o_sda_o/o_sda_en open-drain sda drive (o_sda_o is always 0); o_reg_addr/o_reg_wdata/o_reg_wen/
//        o_reg_ren/i_reg_rdata register port; o_busy high from an accepted address until STOP or master NACK.
module i2c_slave_ctrl #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   input  logic       i_sda_i,
   output logic       o_sda_o,
   output logic       o_sda_en,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_wen,
   output logic       o_reg_ren,
   input  logic [7:0] i_reg_rdata,
   output logic       o_busy
);
   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   localparam logic [2:0] FL_MAX = 3'(FILTER_LEN - 1);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_scl_sync, r_sda_sync;
   logic [2:0] r_scl_cnt, r_sda_cnt;
   logic       r_scl_f, r_sda_f, r_scl_d, r_sda_d;
   logic [7:0] r_shift, r_reg_addr, r_reg_wdata;
   logic [2:0] r_bitcnt;
   logic       r_rw, r_sda_en, r_reg_wen, r_reg_ren, r_cap, r_busy;
   logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_addr_hit, w_sda_en_nxt;
   logic [7:0] w_byte;

   // Synchronizer plus glitch filter: a filtered level only flips after FILTER_LEN
   // consecutive samples disagree with it. Idle bus level is 1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_cnt  <= '0;
         r_sda_cnt  <= '0;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i_scl};
         r_sda_sync <= {r_sda_sync[0], i_sda_i};
         r_scl_d    <= r_scl_f;
         r_sda_d    <= r_sda_f;
         if (r_scl_sync[1] == r_scl_f) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == FL_MAX) begin
            r_scl_f   <= r_scl_sync[1];
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + 3'd1;
         end
         if (r_sda_sync[1] == r_sda_f) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == FL_MAX) begin
            r_sda_f   <= r_sda_sync[1];
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + 3'd1;
         end
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_d;
   assign w_scl_fall = ~r_scl_f & r_scl_d;
   assign w_start    = r_scl_f & r_sda_d & ~r_sda_f;
   assign w_stop     = r_scl_f & ~r_sda_d & r_sda_f;
   assign w_last     = (r_bitcnt == 3'd7);
   assign w_byte     = {r_shift[6:0], r_sda_f};
   assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state. In the ACK states the registered drive doubles as the phase flag:
   // first scl fall starts the ACK, the second one (drive already on) leaves the state.
   always_comb begin
      w_state_nxt = r_state;
      if (w_stop) begin
         w_state_nxt = IDLE;
      end else if (w_start) begin
         w_state_nxt = DEV_ADDR;
      end else begin
         case (r_state)
            DEV_ADDR:  if (w_scl_rise && w_last) w_state_nxt = w_addr_hit ? DEV_ACK : WAIT_STOP;
            DEV_ACK:   if (w_scl_fall && r_sda_en) w_state_nxt = r_rw ? RDATA : WORD_ADDR;
            WORD_ADDR: if (w_scl_rise && w_last) w_state_nxt = WORD_ACK;
            WORD_ACK:  if (w_scl_fall && r_sda_en) w_state_nxt = WDATA;
            WDATA:     if (w_scl_rise && w_last) w_state_nxt = WDATA_ACK;
            WDATA_ACK: if (w_scl_fall && r_sda_en) w_state_nxt = WDATA;
            RDATA:     if (w_scl_rise && w_last) w_state_nxt = RDATA_ACK;
            RDATA_ACK: if (w_scl_rise) w_state_nxt = r_sda_f ? WAIT_STOP : RDATA;
            default:   ;
         endcase
      end
   end

   // Next sda drive: only moves on scl fall, except START/STOP which release at once.
   always_comb begin
      w_sda_en_nxt = r_sda_en;
      if (w_start || w_stop) begin
         w_sda_en_nxt = 1'b0;
      end else if (w_scl_fall) begin
         case (r_state)
            DEV_ACK:             w_sda_en_nxt = r_sda_en ? (r_rw & ~r_shift[7]) : 1'b1;
            WORD_ACK, WDATA_ACK: w_sda_en_nxt = ~r_sda_en;
            RDATA:               w_sda_en_nxt = ~r_shift[7];
            default:             w_sda_en_nxt = 1'b0;
         endcase
      end
   end

   // Datapath: shifter, bit counter, register-port strobes and pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sda_en    <= 1'b0;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_rw        <= 1'b0;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_reg_wen   <= 1'b0;
         r_reg_ren   <= 1'b0;
         r_cap       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_sda_en  <= w_sda_en_nxt;
         r_reg_wen <= 1'b0;
         r_reg_ren <= 1'b0;
         r_cap     <= r_reg_ren;
         if (w_stop) begin
            r_busy   <= 1'b0;
            r_bitcnt <= '0;
         end else if (w_start) begin
            r_bitcnt <= '0;
         end else if (w_scl_rise) begin
            case (r_state)
               DEV_ADDR, WORD_ADDR, WDATA: begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;   // wraps to 0 after the 8th bit
                  if (w_last) begin
                     if (r_state == DEV_ADDR && w_addr_hit) begin
                        r_busy    <= 1'b1;
                        r_rw      <= r_sda_f;
                        r_reg_ren <= r_sda_f;
                     end
                     if (r_state == WORD_ADDR) r_reg_addr <= w_byte;
                     if (r_state == WDATA) begin
                        r_reg_wdata <= w_byte;
                        r_reg_wen   <= 1'b1;
                     end
                  end
               end
               RDATA: begin
                  r_shift  <= {r_shift[6:0], 1'b0};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               RDATA_ACK: begin
                  if (r_sda_f) r_busy    <= 1'b0;
                  else         r_reg_ren <= 1'b1;
               end
               default: ;
            endcase
         end
         // Read byte arrives one clk after reg_ren; each loaded byte advances the pointer.
         if (r_cap) begin
            r_shift    <= i_reg_rdata;
            r_reg_addr <= r_reg_addr + 8'd1;
         end
         // Pointer advances the clk after the write strobe so the write sees the old value.
         if (r_reg_wen) r_reg_addr <= r_reg_addr + 8'd1;
      end
   end

   assign o_sda_o     = 1'b0;
   assign o_sda_en    = r_sda_en;
   assign o_reg_addr  = r_reg_addr;
   assign o_reg_wdata = r_reg_wdata;
   assign o_reg_wen   = r_reg_wen;
   assign o_reg_ren   = r_reg_ren;
   assign o_busy      = r_busy;
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Purpose: self-checking bench for i2c_slave_ctrl driving a bit-banged I2C master with an open-drain bus model.
// Latency: scl runs at 40 clk per bit; writes/read bytes are checked through queues of expected results.
// Backpressure: none; the register model answers reg_ren with reg_addr+0x20 one clk later.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;
   localparam int Q = 10;   // clk cycles per quarter scl period

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_o, sda_en, reg_wen, reg_ren, busy, bus_sda;
   logic [7:0] reg_addr, reg_wdata;
   logic [7:0] reg_rdata = 8'h00;

   int nchecks = 0, nerrors = 0, en_cycles = 0, ren_count = 0;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] rd_q[$];

   typedef struct packed {
      logic [7:0]      dev;
      logic [7:0]      ptr;
      logic [1:0]      nb;
      logic [1:0][7:0] d;
      logic            ack;
      logic [7:0]      addr_after;
   } vec_t;
   vec_t vecs [4];

   assign bus_sda = m_sda & ~(sda_en & ~sda_o);

   always #5 clk = ~clk;

   i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scl(m_scl), .i_sda_i(bus_sda),
      .o_sda_o(sda_o), .o_sda_en(sda_en), .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata),
      .o_reg_wen(reg_wen), .o_reg_ren(reg_ren), .i_reg_rdata(reg_rdata), .o_busy(busy)
   );

   // Register-port model: byte at address a reads as a+0x20, valid 1 clk after reg_ren.
   always @(posedge clk) if (reg_ren) reg_rdata <= reg_addr + 8'h20;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write scoreboard and activity counters.
   always @(negedge clk) begin
      if (sda_en) en_cycles++;
      if (reg_ren) ren_count++;
      if (rst_n && reg_wen) begin
         if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL wen_unexpected: got write addr %0h data %0h expected no write", reg_addr, reg_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wen_addr", reg_addr, mon_e.addr);
            chk("wen_data", reg_wdata, mon_e.data);
         end
      end
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      wait_q(); m_sda = b;
      wait_q(); m_scl = 1'b1;
      wait_q(); s = bus_sda;
      wait_q(); m_scl = 1'b0;
   endtask

   task automatic bus_start();
      wait_q(); m_sda = 1'b1;
      wait_q(); m_scl = 1'b1;
      wait_q(); m_sda = 1'b0;
      wait_q(); m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_q(); m_sda = 1'b0;
      wait_q(); m_scl = 1'b1;
      wait_q(); m_sda = 1'b1;
      wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(~mack, s);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, checks %0d", nchecks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       ack, s;
      logic [7:0] d, ptr;
      int         e0, r0;

      vecs[0] = '{dev: 8'hA0, ptr: 8'h10, nb: 2'd2, d: 16'hC35A, ack: 1'b1, addr_after: 8'h12};
      vecs[1] = '{dev: 8'hA0, ptr: 8'hFF, nb: 2'd2, d: 16'h0201, ack: 1'b1, addr_after: 8'h01};
      vecs[2] = '{dev: 8'hB0, ptr: 8'h11, nb: 2'd0, d: 16'h0000, ack: 1'b0, addr_after: 8'h01};
      vecs[3] = '{dev: 8'hA0, ptr: 8'h7E, nb: 2'd1, d: 16'h0033, ack: 1'b1, addr_after: 8'h7F};

      repeat (4) @(negedge clk);
      chk("rst_sda_en", sda_en, 1'b0);
      chk("rst_sda_o", sda_o, 1'b0);
      chk("rst_reg_addr", reg_addr, 8'h00);
      chk("rst_reg_wdata", reg_wdata, 8'h00);
      chk("rst_reg_wen", reg_wen, 1'b0);
      chk("rst_reg_ren", reg_ren, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Write transactions, including pointer wrap and an address mismatch.
      for (int v = 0; v < 4; v++) begin
         e0 = en_cycles;
         bus_start();
         send_byte(vecs[v].dev, ack);
         chk("dev_ack", ack, vecs[v].ack);
         chk("busy_mid", busy, vecs[v].ack);
         send_byte(vecs[v].ptr, ack);
         chk("ptr_ack", ack, vecs[v].ack);
         for (int b = 0; b < int'(vecs[v].nb); b++) begin
            if (vecs[v].ack) exp_q.push_back('{addr: 8'(vecs[v].ptr + 8'(b)), data: vecs[v].d[b]});
            send_byte(vecs[v].d[b], ack);
            chk("data_ack", ack, vecs[v].ack);
         end
         bus_stop();
         chk("busy_end", busy, 1'b0);
         chk("addr_after", reg_addr, vecs[v].addr_after);
         if (!vecs[v].ack) chk("sda_quiet", en_cycles - e0, 0);
         chk("wq_empty", exp_q.size(), 0);
      end

      // Random read: set pointer, repeated START, read two bytes (ACK then NACK).
      ptr = 8'h20;
      bus_start();
      send_byte(8'hA0, ack); chk("rr_dev_ack", ack, 1'b1);
      send_byte(ptr, ack);   chk("rr_ptr_ack", ack, 1'b1);
      r0 = ren_count;
      bus_start();
      for (int i = 0; i < 2; i++) rd_q.push_back(8'(ptr + 8'(i) + 8'h20));
      send_byte(8'hA1, ack); chk("rr_rd_ack", ack, 1'b1);
      read_byte(1'b1, d);    chk("rr_byte0", d, rd_q.pop_front());
      read_byte(1'b0, d);    chk("rr_byte1", d, rd_q.pop_front());
      chk("rr_busy_nack", busy, 1'b0);
      bus_stop();
      chk("rr_ren_count", ren_count - r0, 2);
      chk("rr_addr", reg_addr, 8'h22);

      // STOP after 4 bits of a data byte: no write, pointer kept, bus released.
      bus_start();
      send_byte(8'hA0, ack); chk("ab_dev_ack", ack, 1'b1);
      send_byte(8'h50, ack); chk("ab_ptr_ack", ack, 1'b1);
      for (int i = 0; i < 4; i++) clock_bit(i[0], s);
      bus_stop();
      chk("ab_busy", busy, 1'b0);
      chk("ab_sda_en", sda_en, 1'b0);
      chk("ab_addr", reg_addr, 8'h50);

      // 2-clk scl glitch before a data byte must not be taken as a bit.
      bus_start();
      send_byte(8'hA0, ack); chk("gl_dev_ack", ack, 1'b1);
      send_byte(8'h60, ack); chk("gl_ptr_ack", ack, 1'b1);
      wait_q(); m_sda = 1'b0;
      wait_q(); m_scl = 1'b1;
      repeat (2) @(negedge clk);
      m_scl = 1'b0;
      exp_q.push_back('{addr: 8'h60, data: 8'h77});
      send_byte(8'h77, ack); chk("gl_data_ack", ack, 1'b1);
      bus_stop();
      chk("gl_addr", reg_addr, 8'h61);
      chk("gl_wq_empty", exp_q.size(), 0);

      // Reset while the slave drives a 0 read bit (byte 0x50 at pointer 0x30).
      bus_start();
      send_byte(8'hA0, ack); chk("rs_dev_ack", ack, 1'b1);
      send_byte(8'h30, ack); chk("rs_ptr_ack", ack, 1'b1);
      bus_start();
      send_byte(8'hA1, ack); chk("rs_rd_ack", ack, 1'b1);
      wait_q();
      chk("rs_driving", sda_en, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rs_release", sda_en, 1'b0);
      chk("rs_addr", reg_addr, 8'h00);
      chk("rs_busy", busy, 1'b0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      bus_start();
      send_byte(8'hA0, ack); chk("pr_dev_ack", ack, 1'b1);
      send_byte(8'h44, ack); chk("pr_ptr_ack", ack, 1'b1);
      exp_q.push_back('{addr: 8'h44, data: 8'h99});
      send_byte(8'h99, ack); chk("pr_data_ack", ack, 1'b1);
      bus_stop();
      chk("pr_addr", reg_addr, 8'h45);
      chk("pr_busy", busy, 1'b0);
      chk("pr_wq_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule
